// File: rtl/tpm_mm_pkg.sv
// rtl/tpm_mm_pkg.sv - shared management-module encodings
// Purpose : op-state, command-code and response-code constants shared by
//           every block that talks to the TPM management module.
// Ports   : none (package)
package tpm_mm_pkg;

    // Operational states reported by management_module
    localparam logic [2:0] OP_POWER_OFF      = 3'b000;
    localparam logic [2:0] OP_INITIALIZATION = 3'b001;
    localparam logic [2:0] OP_STARTUP        = 3'b010;
    localparam logic [2:0] OP_OPERATIONAL    = 3'b011;
    localparam logic [2:0] OP_SELF_TEST      = 3'b100;
    localparam logic [2:0] OP_FAILURE_MODE   = 3'b101;
    localparam logic [2:0] OP_SHUTDOWN       = 3'b110;

    // TPM command codes
    localparam logic [31:0] CC_STARTUP             = 32'h0000_0144;
    localparam logic [31:0] CC_SHUTDOWN            = 32'h0000_0145;
    localparam logic [31:0] CC_SELFTEST            = 32'h0000_0143;
    localparam logic [31:0] CC_INCREMENTALSELFTEST = 32'h0000_0142;
    localparam logic [31:0] CC_HIERARCHYCONTROL    = 32'h0000_0121;

    // TPM response codes
    localparam logic [31:0] RC_SUCCESS    = 32'h0000_0000;
    localparam logic [31:0] RC_INITIALIZE = 32'h0000_0100;
    localparam logic [31:0] RC_FAILURE    = 32'h0000_0101;

endpackage

// File: rtl/mm_cmd_driver.sv
// rtl/mm_cmd_driver.sv - host-to-management-module command strobe driver
// Purpose : accepts one host command at a time, strobes it into the
//           management module with keyStart_n, waits for the outputs to
//           settle, captures the response and hands it back to the host.
// Ports   : clock, reset_n          - clock, async active-low reset
//           req_valid/req_ready     - host command handshake
//           req_cc, req_param       - host command code / parameters
//           tpm_cc, cmd_param       - latched command to management module
//           keyStart_n              - active-low command strobe
//           op_state, tpm_rc        - management module outputs
//           rsp_valid/rsp_ready     - host response handshake
//           rsp_rc, rsp_op_state    - captured response
//           rsp_failure             - captured failure indication
module mm_cmd_driver
    import tpm_mm_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int GAP_CYCLES    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_cc,
    input  logic [32:0] req_param,
    output logic [31:0] tpm_cc,
    output logic [32:0] cmd_param,
    output logic        keyStart_n,
    input  logic [2:0]  op_state,
    input  logic [31:0] tpm_rc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rc,
    output logic [2:0]  rsp_op_state,
    output logic        rsp_failure
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        SETTLE,
        RESP,
        GAP
    } state_t;

    // The counter holds "cycles remaining minus one", so a phase ends on 0.
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD    = 4'(GAP_CYCLES - 1);

    state_t     state;
    state_t     stateNext;
    logic [3:0] cnt;
    logic [3:0] cntNext;
    logic       readyEn;
    logic       accept;
    logic       capture;

    // readyEn keeps req_ready low while in reset and rises on the first
    // clock edge afterwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            readyEn <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            readyEn <= 1'b1;
        end
    end

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        req_ready  = 1'b0;
        keyStart_n = 1'b1;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = readyEn;
                if (req_valid && readyEn) begin
                    accept    = 1'b1;
                    stateNext = SETUP;
                    cntNext   = 4'd0;
                end
            end
            SETUP: begin
                stateNext = STROBE;
                cntNext   = STROBE_LOAD;
            end
            STROBE: begin
                keyStart_n = 1'b0;
                if (cnt == 4'd0) begin
                    stateNext = SETTLE;
                    cntNext   = SETTLE_LOAD;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    stateNext = RESP;
                    cntNext   = 4'd0;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    stateNext = GAP;
                    cntNext   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt == 4'd0) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 4'd0;
            end
        endcase
    end

    // Command is latched only on accept, so it stays put until the next one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tpm_cc    <= 32'd0;
            cmd_param <= 33'd0;
        end else if (accept) begin
            tpm_cc    <= req_cc;
            cmd_param <= req_param;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_rc       <= 32'd0;
            rsp_op_state <= 3'd0;
            rsp_failure  <= 1'b0;
        end else if (capture) begin
            rsp_rc       <= tpm_rc;
            rsp_op_state <= op_state;
            rsp_failure  <= (op_state == OP_FAILURE_MODE) || (tpm_rc == RC_FAILURE);
        end
    end

endmodule
